// File: rtl/gate_bist_pkg.sv
// Shared constants for the gate BIST: FSM state encoding and reference truth tables.
// Truth-table bit k is the expected gate output for input vector k.
package gate_bist_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_XOR2  = 4'b0110;
   localparam logic [3:0] TT_NAND2 = 4'b0111;

   // Wide enough for SETTLE up to 15 plus the one increment past terminal count.
   localparam int CNT_W = 4;

endpackage

// File: rtl/gate_bist_settle_cnt.sv
// Settle-time up-counter for the gate BIST: load, clear, enable, and a
// terminal-count flag asserted while the count equals SETTLE-1.
module gate_bist_settle_cnt
   import gate_bist_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             ld,
   input  logic [CNT_W-1:0] ld_val,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (ld) begin
         cnt <= ld_val;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = (cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/gate_bist.sv
// Gate BIST: walks every input vector of a small combinational gate, samples its
// output after SETTLE cycles and counts mismatches against TRUTH.
// Optional first-failure log ports are built when GATE_BIST_LOG_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for start, no result yet
// ST_DRIVE  | vec driven onto dut_in, settle counter running
// ST_SAMPLE | one cycle, dut_y compared against TRUTH[vec]
// ST_DONE   | run finished, pass/err_cnt valid
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter int                  N_IN   = 2,
   parameter logic [2**N_IN-1:0]  TRUTH  = TT_AND2,
   parameter int                  SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_y,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt
`ifdef GATE_BIST_LOG_EN
   ,
   output logic [N_IN-1:0] fail_vec,
   output logic            fail_y
`endif
);

   logic [1:0]       state;
   logic [N_IN-1:0]  vec;
   logic [CNT_W-1:0] settle_cnt;
   logic             settle_tc;
   logic             accept;
   logic             last_vec;
   logic             mismatch;
   logic             cnt_clr;

   assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign last_vec = (vec == {N_IN{1'b1}});
   assign mismatch = (dut_y != TRUTH[vec]);
   assign cnt_clr  = accept || ((state == ST_SAMPLE) && !last_vec);

   gate_bist_settle_cnt #(
      .SETTLE (SETTLE)
   ) u_settle_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .ld     (1'b0),
      .ld_val ('0),
      .en     (state == ST_DRIVE),
      .cnt    (settle_cnt),
      .tc     (settle_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         vec     <= '0;
         err_cnt <= '0;
      end else begin
         case (state)
            ST_DRIVE: begin
               if (settle_tc) state <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               if (mismatch) err_cnt <= err_cnt + (N_IN+1)'(1);
               if (last_vec) begin
                  state <= ST_DONE;
               end else begin
                  vec   <= vec + N_IN'(1);
                  state <= ST_DRIVE;
               end
            end
            default: begin
               if (start) begin
                  state   <= ST_DRIVE;
                  vec     <= '0;
                  err_cnt <= '0;
               end
            end
         endcase
      end
   end

`ifdef GATE_BIST_LOG_EN
   // Capture only the first mismatch of a run, i.e. while err_cnt is still zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_vec <= '0;
         fail_y   <= 1'b0;
      end else if (accept) begin
         fail_vec <= '0;
         fail_y   <= 1'b0;
      end else if ((state == ST_SAMPLE) && mismatch && (err_cnt == '0)) begin
         fail_vec <= vec;
         fail_y   <= dut_y;
      end
   end
`endif

   assign dut_in = vec;
   assign busy   = (state == ST_DRIVE) || (state == ST_SAMPLE);
   assign done   = (state == ST_DONE);
   assign pass   = done && (err_cnt == '0);

   logic unused_cnt;
   assign unused_cnt = ^settle_cnt;

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: directed runs push expected results, monitors
// compare when done rises. Log outputs are checked when GATE_BIST_LOG_EN is defined.
module tb_gate_bist;
   import gate_bist_pkg::*;

   typedef struct {
      logic [2:0] err;
      logic       pass;
      logic [1:0] fv;
      logic       fy;
      int         lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic [1:0] dut_in0, dut_in1;
   logic       dut_y0, dut_y1;
   logic       busy0, busy1, done0, done1, pass0, pass1;
   logic [2:0] err_cnt0, err_cnt1;
   logic [1:0] fv0, fv1;
   logic       fy0, fy1;

   int   gate_mode = 0;
   int   cyc = 0;
   int   acc0 = 0;
   int   acc1 = 0;
   int   errors = 0;
   int   checks = 0;
   logic done0_q = 1'b0;
   logic done1_q = 1'b0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Gate models: 0 = AND, 1 = stuck-at-0, 2 = NAND
   always_comb begin
      dut_y0 = 1'b0;
      case (gate_mode)
         0:       dut_y0 = dut_in0[1] & dut_in0[0];
         2:       dut_y0 = ~(dut_in0[1] & dut_in0[0]);
         default: dut_y0 = 1'b0;
      endcase
   end
   assign dut_y1 = dut_in1[1] ^ dut_in1[0];

   gate_bist #(.N_IN(2), .TRUTH(TT_AND2), .SETTLE(2)) u0 (
      .clk(clk), .rst(rst), .start(start0), .dut_in(dut_in0), .dut_y(dut_y0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0)
`ifdef GATE_BIST_LOG_EN
      , .fail_vec(fv0), .fail_y(fy0)
`endif
   );

   gate_bist #(.N_IN(2), .TRUTH(TT_XOR2), .SETTLE(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .dut_in(dut_in1), .dut_y(dut_y1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1)
`ifdef GATE_BIST_LOG_EN
      , .fail_vec(fv1), .fail_y(fy1)
`endif
   );

`ifndef GATE_BIST_LOG_EN
   assign fv0 = 2'b00;
   assign fy0 = 1'b0;
   assign fv1 = 2'b00;
   assign fy1 = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_result(input string tag, input exp_t e, input logic [2:0] err,
                             input logic pass, input logic [1:0] fv, input logic fy,
                             input int lat, input logic busy);
      chk({tag, "_err_cnt"}, err, e.err);
      chk({tag, "_pass"}, pass, e.pass);
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_busy_at_done"}, busy, 1'b0);
`ifdef GATE_BIST_LOG_EN
      chk({tag, "_fail_vec"}, fv, e.fv);
      chk({tag, "_fail_y"}, fy, e.fy);
`endif
   endtask

   always @(negedge clk) begin
      if (!rst && busy0) chk("dut_in0_seq", dut_in0, (cyc - acc0) / 3);
      if (!rst && busy1) chk("dut_in1_seq", dut_in1, (cyc - acc1) / 2);
      if (done0 && !done0_q) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done0: got done=1 expected no pending run");
         end else begin
            cmp_result("run0", q0.pop_front(), err_cnt0, pass0, fv0, fy0, cyc - acc0, busy0);
         end
      end
      if (done1 && !done1_q) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done1: got done=1 expected no pending run");
         end else begin
            cmp_result("run1", q1.pop_front(), err_cnt1, pass1, fv1, fy1, cyc - acc1, busy1);
         end
      end
      done0_q = done0;
      done1_q = done1;
   end

   task automatic pulse0();
      @(negedge clk);
      start0 = 1'b1;
      acc0   = cyc + 1;
      @(negedge clk);
      start0 = 1'b0;
      chk("accept0_done", done0, 1'b0);
      chk("accept0_err_cnt", err_cnt0, 0);
      chk("accept0_busy", busy0, 1'b1);
   endtask

   task automatic pulse1();
      @(negedge clk);
      start1 = 1'b1;
      acc1   = cyc + 1;
      @(negedge clk);
      start1 = 1'b0;
      chk("accept1_done", done1, 1'b0);
      chk("accept1_err_cnt", err_cnt1, 0);
      chk("accept1_busy", busy1, 1'b1);
   endtask

   task automatic wait_done0();
      int n = 0;
      while (!done0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done0) begin
         checks++; errors++;
         $display("FAIL timeout0: got done=0 expected done=1 within 40 cycles");
      end
      @(negedge clk);
   endtask

   task automatic wait_done1();
      int n = 0;
      while (!done1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done1) begin
         checks++; errors++;
         $display("FAIL timeout1: got done=0 expected done=1 within 40 cycles");
      end
      @(negedge clk);
   endtask

   task automatic run0(input int mode, input logic [2:0] err, input logic pass,
                       input logic [1:0] fv, input logic fy);
      gate_mode = mode;
      q0.push_back('{err: err, pass: pass, fv: fv, fy: fy, lat: 12});
      pulse0();
      wait_done0();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_dut_in", dut_in0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_pass", pass0, 0);
      chk("rst_err_cnt", err_cnt0, 0);
      chk("rst_done1", done1, 0);
      rst = 1'b0;

      run0(0, 3'd0, 1'b1, 2'd0, 1'b0);   // correct AND
      run0(1, 3'd1, 1'b0, 2'd3, 1'b0);   // stuck-at-0
      run0(2, 3'd4, 1'b0, 2'd0, 1'b1);   // NAND against AND table

      // stray starts mid-run must be ignored
      gate_mode = 2;
      q0.push_back('{err: 3'd4, pass: 1'b0, fv: 2'd0, fy: 1'b1, lat: 12});
      pulse0();
      for (int k = 1; k < 12; k++) begin
         @(negedge clk);
         start0 = (k == 3 || k == 7);
      end
      start0 = 1'b0;
      wait_done0();

      // reset during SAMPLE of vector 2
      gate_mode = 2;
      pulse0();
      repeat (8) @(negedge clk);
      chk("pre_rst_dut_in", dut_in0, 2);
      chk("pre_rst_err_cnt", err_cnt0, 2);
      rst = 1'b1;
      #1;
      chk("mid_rst_dut_in", dut_in0, 0);
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_done", done0, 0);
      chk("mid_rst_err_cnt", err_cnt0, 0);
      @(negedge clk);
      rst = 1'b0;
      run0(1, 3'd1, 1'b0, 2'd3, 1'b0);

      // XOR gate with SETTLE=1, twice back to back from DONE
      for (int r = 0; r < 2; r++) begin
         q1.push_back('{err: 3'd0, pass: 1'b1, fv: 2'd0, fy: 1'b0, lat: 8});
         pulse1();
         wait_done1();
      end

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
